// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants and the fetch-PC state type.
package cpu_pkg;

   localparam int unsigned XLEN       = 64;
   localparam int unsigned INSN_BYTES = 4;

   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } pc_state_t;

endpackage

// File: rtl/pc_add64.sv
// Plain XLEN-bit modulo adder; carry out is intentionally discarded.
module pc_add64
   import cpu_pkg::*;
(
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic [XLEN-1:0] sum
);

   assign sum = a + b;

endmodule

// File: rtl/pc_next_unit.sv
// Next-fetch-PC generator: sequential advance, taken-branch redirect and flush timing.
//
// state | meaning
// IDLE  | first cycle after reset release, no fetch issued, inputs ignored
// RUN   | fetching sequentially, no flush pending
// FLUSH | redirect taken, flush held while the flush counter is nonzero
module pc_next_unit
   import cpu_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC     = RESET_PC_DEFAULT,
   parameter int unsigned     FLUSH_CYCLES = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            branch_valid,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_pc,
   input  logic [XLEN-1:0] branch_offset,
   input  logic            stall,
   input  logic            fetch_ready,
   output logic            fetch_valid,
   output logic [XLEN-1:0] fetch_addr,
   output logic            flush,
   output logic [31:0]     taken_count
);

   localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

   pc_state_t       state_q, state_d;
   logic [2:0]      cnt_q, cnt_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [31:0]     count_q, count_d;

   logic [XLEN-1:0] seq_addr;
   logic [XLEN-1:0] target_addr;
   logic            taken;

   pc_add64 u_seq_add (
      .a   (addr_q),
      .b   (XLEN'(INSN_BYTES)),
      .sum (seq_addr)
   );

   pc_add64 u_target_add (
      .a   (branch_pc),
      .b   (branch_offset),
      .sum (target_addr)
   );

   assign taken = branch_valid & branch_taken;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      count_d = count_q;
      case (state_q)
         IDLE: state_d = RUN;
         default: begin
            // A redirect outranks stall; stall only gates the +4 path.
            if (taken) begin
               addr_d  = target_addr;
               cnt_d   = FLUSH_LOAD;
               state_d = FLUSH;
               if (count_q != 32'hFFFF_FFFF) count_d = count_q + 32'd1;
            end else begin
               if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
               if (fetch_ready && !stall) addr_d = seq_addr;
               state_d = (cnt_q > 3'd1) ? FLUSH : RUN;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 3'd0;
         addr_q  <= RESET_PC;
         count_q <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         count_q <= count_d;
      end
   end

   assign fetch_valid = (state_q != IDLE);
   assign flush       = (cnt_q != 3'd0);
   assign fetch_addr  = addr_q;
   assign taken_count = count_q;

endmodule
